byte_serial_add_sequencer: RTL and testbench
============================================

// Module: byte_serial_add_sequencer
// PURPOSE
//  Sequences one shared 8-bit carry-lookahead adder (carry_look_ahead_adder_cin8) over
//  NBYTES cycles to perform a wide ADD/SUB, least-significant byte first.
//  Sits between ALU issue logic and the adder; trades latency for area in the CPU datapath.
//  Single requester, start/busy/done handshake; the result is held until the next accepted start.
// PARAMETERS
//  NBYTES   2   operand width in bytes (W = 8*NBYTES); legal range 1..8
// PORTS
//  clk      in   1   single clock, rising edge
//  rst_n    in   1   asynchronous active-low reset
//  start    in   1   request; accepted only when busy==0
//  op_sub   in   1   0: A+B, 1: A-B (sampled with start)
//  a        in   W   operand A (sampled with start)
//  b        in   W   operand B (sampled with start)
//  busy     out  1   operation in progress
//  done     out  1   one-cycle pulse: result/cout/ovf valid
//  result   out  W   sum/difference; held between operations
//  cout     out  1   carry out of MSB (SUB: 1 = no borrow)
//  ovf      out  1   signed overflow (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, cout, ovf = 0; result = 0; byte counter = 0; carry reg = 0.
//  FSM IDLE -> RUN on start&&!busy; RUN -> IDLE when counter==NBYTES-1 (last byte added).
//  Accept edge T0: latch a into A shift reg; latch b (or ~b if op_sub) into B shift reg; carry=op_sub.
//  RUN cycle k (k=0..NBYTES-1): adder inputs A[7:0], B[7:0], cin=carry; at the edge, shift A/B
//   right by 8, shift R into result from the top, carry <= (a7&b7)|((a7|b7)&~r7) of that byte.
//  Latency: busy high from edge T0 to edge T0+NBYTES; done=1 for exactly the cycle after
//   edge T0+NBYTES; cout/ovf update at the same edge as done.
//  result reads as an intermediate value while busy; it is valid from done onward.
//  result is stable after done until the next accepted start.
//  start while busy: ignored, no queuing; internal registers are untouched.
//  start during the done cycle: accepted (busy==0); done falls, busy rises at the next edge.
//  NBYTES==1: single RUN cycle; done appears one cycle after acceptance.
//  rst_n low mid-operation: immediate return to reset values; no done is produced.
//  Arithmetic modulo 2^W; carry chain is internal to the sequencer only.
// CONFIGURATION
//  SEQ_ADD_OVERFLOW_EN defined: ovf = carry_into_MSB ^ cout, where carry_into_MSB = a7^b7^r7
//   of the top byte (b7 post-inversion); registered alongside cout.
//  Not defined: ovf tied to 0; overflow logic is not generated; the port is kept for interface stability.
// STRUCTURE
//  Package seq_add_pkg: BYTE_W=8 constant, state enum {IDLE, RUN}, counter width function clog2(NBYTES).
//  Sole sub-module instance: carry_look_ahead_adder_cin8 (existing, unmodified); carry-out is
//   derived in the sequencer because the adder exposes no cout.
//  No other sub-modules: FSM, counter, and shift regs are local.
// TESTING (NBYTES=2 unless stated)
//  ADD 0x1234+0x0FCD -> done 2 cycles after accept, result=0x2201, cout=0, ovf=0.
//  ADD 0xFFFF+0x0001 -> result=0x0000, cout=1, ovf=0 (ovf=0 also without the macro).
//  SUB 0x8000-0x0001 -> result=0x7FFF, cout=1, ovf=1 with SEQ_ADD_OVERFLOW_EN; ovf=0 without.
//  start (ADD 1+1) pulsed while busy on ADD 0x00FF+0x0001 -> ignored; result=0x0100, single done.
//  rst_n low for 1 cycle during RUN -> busy=0, done never pulses, result=0; next op is correct.
//  Back-to-back: start held high through done cycle -> second op accepted, done every 3 cycles.

Source files
------------

// File: rtl/byte_serial_add_sequencer_pkg.sv
// Shared constants and types for the byte-serial add/sub sequencer.
package seq_add_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Byte-counter width; never narrower than one bit so NBYTES==1 still has a counter
  function automatic int clog2(input int n);
    int w;
    w = 32'sd0;
    for (int i = 0; i < 32; i++) begin
      if ((32'sd1 << i) < n) begin
        w = i + 32'sd1;
      end else begin
        w = w;
      end
    end
    return (w < 32'sd1) ? 32'sd1 : w;
  endfunction

endpackage

// File: rtl/carry_look_ahead_adder_cin8.sv
// 8-bit carry-lookahead adder with carry-in; sum only, no carry-out port.
module carry_look_ahead_adder_cin8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum
);

  logic [7:0] p_s;
  logic [7:0] g_s;
  logic [7:0] c_s;

  function automatic logic [7:0] carries(input logic [7:0] p, input logic [7:0] g, input logic ci);
    logic [7:0] c;
    c[0] = ci;
    for (int i = 0; i < 7; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return c;
  endfunction

  assign p_s = a ^ b;
  assign g_s = a & b;
  assign c_s = carries(p_s, g_s, cin);
  assign sum = p_s ^ c_s;

endmodule

// File: rtl/byte_serial_add_sequencer.sv
// Wide ADD/SUB over one shared 8-bit adder, LS byte first, one byte per cycle.
// Optional signed-overflow output enabled by defining SEQ_ADD_OVERFLOW_EN.
module byte_serial_add_sequencer
  import seq_add_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     op_sub,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  output logic                     busy,
  output logic                     done,
  output logic [BYTE_W*NBYTES-1:0] result,
  output logic                     cout,
  output logic                     ovf
);

  localparam int W  = BYTE_W * NBYTES;
  localparam int CW = clog2(NBYTES);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    res_q, res_d;
  logic            carry_q, carry_d;
  logic            done_q, done_d;
  logic            cout_q, cout_d;

  logic [7:0]          sum_s;
  logic                byte_cout_s;
  logic [W+BYTE_W-1:0] res_cat_s;

  carry_look_ahead_adder_cin8 u_cla (
    .a   (a_q[7:0]),
    .b   (b_q[7:0]),
    .cin (carry_q),
    .sum (sum_s)
  );

  // The adder has no carry-out, so recover it from the MSB operands and MSB sum bit
  assign byte_cout_s = (a_q[7] & b_q[7]) | ((a_q[7] | b_q[7]) & ~sum_s[7]);
  assign res_cat_s   = {sum_s, res_q};

`ifdef SEQ_ADD_OVERFLOW_EN
  logic ovf_q, ovf_d;
  logic msb_cin_s;

  assign msb_cin_s = a_q[7] ^ b_q[7] ^ sum_s[7];

  // Overflow flag register, updated together with cout on the last byte
  always_comb begin
    ovf_d = ovf_q;
    if ((state_q == RUN) && (cnt_q == LAST)) begin
      ovf_d = msb_cin_s ^ byte_cout_s;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  // Next-state, datapath shift and handshake logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          a_d     = a;
          b_d     = op_sub ? ~b : b;
          carry_d = op_sub;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> BYTE_W;
        b_d     = b_q >> BYTE_W;
        res_d   = res_cat_s[W+BYTE_W-1:BYTE_W];
        carry_d = byte_cout_s;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          cout_d  = byte_cout_s;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign result = res_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_byte_serial_add_sequencer.sv
// Scoreboard bench for byte_serial_add_sequencer: random and directed ADD/SUB
// against an arithmetic reference model.
module tb_byte_serial_add_sequencer;

  localparam int NB = 2;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  int           acc_cyc  = 0;
  logic [W-1:0] last_res = '0;

  byte_serial_add_sequencer #(.NBYTES(NB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_sub (op_sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values
  function automatic exp_t model(input logic sub, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    logic [W:0]  full;
    longint      sx, sy, sr, smax, smin;
    if (sub) begin
      e.res = x - y;
      e.co  = (x >= y);
    end else begin
      full  = {1'b0, x} + {1'b0, y};
      e.res = full[W-1:0];
      e.co  = full[W];
    end
    sx   = $signed(x);
    sy   = $signed(y);
    sr   = sub ? (sx - sy) : (sx + sy);
    smax = (64'sd1 <<< (W - 1)) - 64'sd1;
    smin = -(64'sd1 <<< (W - 1));
`ifdef SEQ_ADD_OVERFLOW_EN
    e.ov = (sr > smax) || (sr < smin);
`else
    e.ov = 1'b0;
`endif
    e.cyc = 0;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected no done (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check("result", 64'(result), 64'(e.res));
        check("cout", 64'(cout), 64'(e.co));
        check("ovf", 64'(ovf), 64'(e.ov));
        check("done_latency_cycle", 64'(cyc), 64'(e.cyc));
        last_res = e.res;
      end
    end
  end

  task automatic issue(input logic sub, input logic [W-1:0] x, input logic [W-1:0] y, input bit hold);
    exp_t e;
    int   k;
    k = 0;
    @(negedge clk);
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("issue_wait_timeout", 64'(busy), 64'(0));
    start  = 1'b1;
    op_sub = sub;
    a      = x;
    b      = y;
    @(posedge clk);
    #1;
    check("accepted_busy", 64'(busy), 64'(1));
    acc_cyc = cyc;
    e       = model(sub, x, y);
    e.cyc   = cyc + NB;
    sb.push_back(e);
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while ((sb.size() != 0 || busy) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) check("done_timeout", 64'(sb.size()), 64'(0));
    @(negedge clk);
    check("result_hold", 64'(result), 64'(last_res));
    check("done_single_pulse", 64'(done), 64'(0));
  endtask

  initial begin
    int c1;
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1;
    rst_n  = 1'b0;
    start  = 1'b0;
    op_sub = 1'b0;
    a      = '0;
    b      = '0;
    #12;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_cout", 64'(cout), 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    issue(1'b0, 16'h1234, 16'h0FCD, 1'b0);
    wait_done();
    check("add_1234_0fcd", 64'(result), 64'(16'h2201));
    check("add_1234_0fcd_cout", 64'(cout), 64'(0));

    issue(1'b0, 16'hFFFF, 16'h0001, 1'b0);
    wait_done();
    check("add_ffff_1", 64'(result), 64'(16'h0000));
    check("add_ffff_1_cout", 64'(cout), 64'(1));
    check("add_ffff_1_ovf", 64'(ovf), 64'(0));

    issue(1'b1, 16'h8000, 16'h0001, 1'b0);
    wait_done();
    check("sub_8000_1", 64'(result), 64'(16'h7FFF));
    check("sub_8000_1_cout", 64'(cout), 64'(1));

    // start pulsed mid-operation must be ignored
    issue(1'b0, 16'h00FF, 16'h0001, 1'b0);
    @(negedge clk);
    start = 1'b1;
    a     = 16'h0001;
    b     = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check("ignored_start_result", 64'(result), 64'(16'h0100));

    // reset in the middle of a run
    issue(1'b0, 16'h1234, 16'h1111, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_result", 64'(result), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_no_done", 64'(done), 64'(0));
    last_res = '0;
    issue(1'b1, 16'h0003, 16'h0005, 1'b0);
    wait_done();
    check("after_rst_sub", 64'(result), 64'(16'hFFFE));

    // start held high through the done cycle
    issue(1'b0, 16'h1111, 16'h2222, 1'b1);
    c1 = acc_cyc;
    issue(1'b1, 16'h4444, 16'h0004, 1'b0);
    check("b2b_spacing", 64'(acc_cyc - c1), 64'(3));
    wait_done();

    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      wait_done();
    end

    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
